// File: rtl/adc_conv_sequencer.sv
// -----------------------------------------------------------------------------
// adc_conv_sequencer
//
// Command sequencer in front of the ADC byte-level SPI controller. For every
// accepted start it writes the setup byte and the conversion byte, waits for
// the ADC end-of-conversion (EOC, active low), then reads one result byte per
// scanned channel (0..last_ch) and presents each byte as a tagged sample.
// This block is the only master of the byte controller.
//
// Parameters
//   SETUP_BYTE      setup-register byte sent first in every sequence
//   TIMEOUT_CYCLES  ref_clk cycles to wait for EOC low before giving up (1..65535)
//
// Ports
//   ref_clk        system clock
//   reset          synchronous, active-high reset
//   start          single-cycle request, accepted only when idle
//   last_ch        highest channel to scan, captured when start is accepted
//   eoc_n          ADC end-of-conversion, active low, asynchronous
//   spi_en/spi_wr  one-cycle issue strobes to the byte controller (identical)
//   spi_wr_data    byte to transmit, held until the matching spi_done
//   spi_rd_data    byte received by the controller
//   spi_done       controller one-cycle completion pulse
//   spi_busy       controller busy
//   sample_data    result byte
//   sample_ch      channel index of sample_data
//   sample_valid   one-cycle strobe qualifying sample_data / sample_ch
//   seq_done       one-cycle pulse one cycle after the last sample
//   timeout_err    one-cycle pulse when EOC never arrived
//   busy           high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_conv_sequencer #(
  parameter logic [7:0]  SETUP_BYTE     = 8'h64,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] last_ch,
  input  logic       eoc_n,
  output logic       spi_en,
  output logic       spi_wr,
  output logic [7:0] spi_wr_data,
  input  logic [7:0] spi_rd_data,
  input  logic       spi_done,
  input  logic       spi_busy,
  output logic [7:0] sample_data,
  output logic [2:0] sample_ch,
  output logic       sample_valid,
  output logic       seq_done,
  output logic       timeout_err,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP_ISSUE,
    S_SETUP_WAIT,
    S_CONV_ISSUE,
    S_CONV_WAIT,
    S_EOC_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0]  READ_BYTE = 8'h00;
  // Last counter value that still counts as waiting; the expiry decision is
  // taken on the edge that moves the counter onto TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LAST  = TIMEOUT_CYCLES - 16'd1;

  // Conversion-register byte: CHSEL = last channel, SCAN = 00, no temperature.
  function automatic logic [7:0] conv_byte(input logic [2:0] ch);
    return {1'b1, 1'b0, ch, 2'b00, 1'b0};
  endfunction

  state_t      state;
  logic [2:0]  ch_last;
  logic [2:0]  ch_cnt;
  logic [15:0] tmo_cnt;
  logic        eoc_n_p0;
  logic        eoc_n_p1;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ch_last      <= 3'd0;
      ch_cnt       <= 3'd0;
      tmo_cnt      <= 16'd0;
      eoc_n_p0     <= 1'b1;
      eoc_n_p1     <= 1'b1;
      spi_en       <= 1'b0;
      spi_wr       <= 1'b0;
      spi_wr_data  <= 8'h00;
      sample_data  <= 8'h00;
      sample_ch    <= 3'd0;
      sample_valid <= 1'b0;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // ---- stage p0 -> p1: EOC synchronizer, free-running in every state ----
      eoc_n_p0 <= eoc_n;
      eoc_n_p1 <= eoc_n_p0;

      // ---- sequencer: pulse outputs default low each cycle ----
      spi_en       <= 1'b0;
      spi_wr       <= 1'b0;
      sample_valid <= 1'b0;
      seq_done     <= 1'b0;
      timeout_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            ch_last <= last_ch;
            ch_cnt  <= 3'd0;
            state   <= S_SETUP_ISSUE;
          end
        end

        S_SETUP_ISSUE: begin
          if (!spi_busy) begin
            spi_en      <= 1'b1;
            spi_wr      <= 1'b1;
            spi_wr_data <= SETUP_BYTE;
            state       <= S_SETUP_WAIT;
          end
        end

        S_SETUP_WAIT: begin
          if (spi_done) begin
            state <= S_CONV_ISSUE;
          end
        end

        S_CONV_ISSUE: begin
          if (!spi_busy) begin
            spi_en      <= 1'b1;
            spi_wr      <= 1'b1;
            spi_wr_data <= conv_byte(ch_last);
            state       <= S_CONV_WAIT;
          end
        end

        S_CONV_WAIT: begin
          if (spi_done) begin
            tmo_cnt <= 16'd0;
            state   <= S_EOC_WAIT;
          end
        end

        // EOC low takes priority over an expiry in the same cycle.
        S_EOC_WAIT: begin
          if (!eoc_n_p1) begin
            state <= S_RD_ISSUE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt     <= tmo_cnt + 16'd1;
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_RD_ISSUE: begin
          if (!spi_busy) begin
            spi_en      <= 1'b1;
            spi_wr      <= 1'b1;
            spi_wr_data <= READ_BYTE;
            state       <= S_RD_WAIT;
          end
        end

        // Compare before increment so a 3-bit counter covers last_ch = 7
        // without wrapping.
        S_RD_WAIT: begin
          if (spi_done) begin
            sample_data  <= spi_rd_data;
            sample_ch    <= ch_cnt;
            sample_valid <= 1'b1;
            if (ch_cnt == ch_last) begin
              state <= S_DONE;
            end else begin
              ch_cnt <= ch_cnt + 3'd1;
              state  <= S_RD_ISSUE;
            end
          end
        end

        S_DONE: begin
          seq_done <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
